muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit for the EX stage of the pipelined core, parametrised in operand width. It accepts one operation at a time from ID_EX operands and func3, and computes for a fixed number of cycles. While it computes, it asserts `busy` so the hazard logic can stall IF/ID/EX. It returns a registered result with a one-cycle `done` pulse, and supports a flush from branch resolution.

## Interface
- `XLEN`, 32: operand/result width; must be ≥ 4. Iteration counter width is clog2(XLEN).
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-low. It is sampled on the rising edge of `clk`.
- `start` input 1: request; accepted only in IDLE.
- `op` input 3: RV32M func3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a` input XLEN: rs1 operand (multiplicand/dividend).
- `b` input XLEN: rs2 operand (multiplier/divisor).
- `flush` input 1: abort the in-flight operation.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse; `result` is valid in that cycle.
- `result` output XLEN: registered result; holds its value until the next completion.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE→CALC: when `start`=1 and `flush`=0.
  - CALC→FIX: after exactly XLEN iterations (counter 0..XLEN-1).
  - FIX→DONE: unconditional.
  - DONE→IDLE: unconditional.
- On accept, latch `op`, `a` and `b`. Later changes on the inputs have no effect on the operation.
- Signedness rules:
  - `a` is signed for MULH, MULHSU, DIV and REM.
  - `b` is signed for MULH, DIV and REM.
  - Signed operands are converted to magnitude at accept. The result sign is recorded for FIX.
- Multiply: unsigned shift-add, 2·XLEN-bit product, one multiplier bit per CALC cycle.
  - In FIX, negate the product if the result sign is negative.
  - MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits.
  - MUL low bits are identical for all signedness choices.
- Divide: restoring division, one quotient bit per CALC cycle, on magnitudes.
  - Quotient is negated if sign(a)≠sign(b).
  - Remainder takes the sign of the dividend.
- Special cases are resolved in FIX. Latency stays fixed with no early-out.
  - Divide by zero: DIV/DIVU → all ones. REM/REMU → `a` as latched.
  - Signed overflow, DIV of the most-negative value by −1: quotient = most-negative value, REM = 0.
- `result` is written only on the FIX→DONE edge.
- `start` outside IDLE is ignored; this includes the DONE cycle. No queuing.
- `flush`:
  - In any state, the next state is IDLE. No `done` is produced and `result` is unchanged.
  - In IDLE, `flush` together with `start` rejects the start.
- Reset, including mid-operation: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0, internal operands 0.

## Timing
- `start` is sampled high in cycle 0. Then:
  - Cycles 1..XLEN: CALC.
  - Cycle XLEN+1: FIX.
  - Cycle XLEN+2: DONE, with `done`=1 and `result` valid.
  - Cycle XLEN+3: IDLE.
- Total latency is XLEN+2 cycles (34 at XLEN=32).
- `busy` is high in cycles 1..XLEN+2 and combinationally decoded from state.
- `done` is high in exactly one cycle per completed operation.
- The earliest back-to-back `start` is cycle XLEN+3.
- `flush` sampled in cycle k with 1≤k≤XLEN+2: `busy`=0 in cycle k+1. A flush in the DONE cycle does not retract the `done` already asserted in that cycle.
- Reset timing: `rst`=0 sampled on an edge gives reset values in the following cycle.

## Test plan
- Multiply:
  - MUL, a=7, b=0xFFFFFFFD → `result`=0xFFFFFFEB, `done` exactly in cycle 34 after start, `busy` high in cycles 1–34.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU, a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- Divide:
  - DIV, a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD.
  - REM with the same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases:
  - DIVU x/0 → 0xFFFFFFFF.
  - REM, a=0x1234, b=0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - All of these complete with the fixed 34-cycle latency.
- Handshake:
  - `start` pulsed in cycles 5 and 33 during an operation → ignored, single `done`.
  - Operand inputs changed mid-operation → `result` unaffected.
  - `start` in cycle 35 → accepted.
- Flush:
  - `flush` in cycle 10 → `busy`=0 in cycle 11, no `done`, `result` keeps the previous value.
  - `flush` together with `start` in IDLE → not accepted.
  - A fresh MUL 3×4 afterwards → 12.
- Reset:
  - `rst`=0 in cycle 20 of a DIV → `busy`, `done` and `result` all 0 in the next cycle, no `done` later.
  - A subsequent operation computes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign and special-case fix-up in a final cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [XLEN-1:0]    a_q;
    logic               a_neg;
    logic               b_neg;
    logic [XLEN-1:0]    hi;
    logic [XLEN-1:0]    lo;
    logic [XLEN-1:0]    opd;

    logic               accept;
    logic               a_signed;
    logic               b_signed;
    logic               a_neg_in;
    logic               b_neg_in;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      div_diff;
    logic [XLEN-1:0]    hi_step;
    logic [XLEN-1:0]    lo_step;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    quot;
    logic [XLEN-1:0]    rem;
    logic               div_zero;
    logic               div_ovf;
    logic [XLEN-1:0]    fix_result;

    assign accept = (state == S_IDLE) && start && !flush;
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (start) state_next = S_CALC;
            S_CALC: if (cnt == CNT_W'(XLEN - 1)) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg_in = a_signed && a[XLEN-1];
        b_neg_in = b_signed && b[XLEN-1];
        a_mag    = a_neg_in ? -a : a;
        b_mag    = b_neg_in ? -b : b;
    end

    // Multiply keeps {hi,lo} as the shifting product; divide keeps remainder in hi, quotient in lo.
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : {(XLEN+1){1'b0}});
        div_diff = {hi, lo[XLEN-1]} - {1'b0, opd};
        hi_step  = mul_sum[XLEN:1];
        lo_step  = {mul_sum[0], lo[XLEN-1:1]};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_step = div_diff[XLEN-1:0];
                lo_step = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_step = {hi[XLEN-2:0], lo[XLEN-1]};
                lo_step = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod       = (a_neg ^ b_neg) ? -{hi, lo} : {hi, lo};
        quot       = (a_neg ^ b_neg) ? -lo : lo;
        rem        = a_neg ? -hi : hi;
        div_zero   = (opd == '0);
        div_ovf    = a_neg && b_neg && (a_q == MOST_NEG) && (opd == XLEN'(1));
        fix_result = '0;
        unique case (op_q)
            OP_MUL:                        fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_result = div_zero ? '1 : (div_ovf ? MOST_NEG : quot);
            OP_REM, OP_REMU:               fix_result = div_zero ? a_q : (div_ovf ? '0 : rem);
            default:                       fix_result = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: datapath registers are reset too, so a reset mid-operation leaves no stale operands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            opd    <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                cnt   <= '0;
                op_q  <= op;
                a_q   <= a;
                a_neg <= a_neg_in;
                b_neg <= b_neg_in;
                hi    <= '0;
                lo    <= op[2] ? a_mag : b_mag;
                opd   <= op[2] ? b_mag : a_mag;
            end else if (state == S_CALC) begin
                cnt <= cnt + 1'b1;
                hi  <= hi_step;
                lo  <= lo_step;
            end
            if ((state == S_FIX) && !flush) begin
                result <= fix_result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of RV32M vectors with hand-computed results,
// plus sequences for ignored starts, flush and mid-operation reset.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts an operation in the current cycle (called just after a falling edge) and
    // watches cycles 1..LAT+1; inputs are scrambled after accept to prove they were latched.
    task automatic run_op(input string name, input logic [2:0] op_in, input logic [31:0] a_in,
                          input logic [31:0] b_in, input logic [31:0] exp, input bit glitch,
                          input int flush_cyc, input int rst_cyc);
        int kill;
        int n_done;
        int done_cyc;
        int busy_err;
        bit exp_busy;
        kill     = (flush_cyc > 0) ? flush_cyc : rst_cyc;
        n_done   = 0;
        done_cyc = 0;
        busy_err = 0;
        start = 1'b1;
        op    = op_in;
        a     = a_in;
        b     = b_in;
        for (int cyc = 1; cyc <= LAT + 1; cyc++) begin
            @(negedge clk);
            exp_busy = (cyc <= LAT) && (kill == 0 || cyc <= kill);
            if (busy !== exp_busy) busy_err++;
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                check({name, "_rst_busy_done"}, {30'd0, busy, done}, 32'd0);
                check({name, "_rst_result"}, result, 32'd0);
            end
            start = glitch && (cyc == 5 || cyc == 33 || cyc == 34);
            op    = ~op_in;
            a     = ~a_in;
            b     = b_in + 32'd1;
            flush = (cyc == flush_cyc);
            rst   = !(cyc == rst_cyc);
        end
        check({name, "_busy_pattern"}, busy_err, 32'd0);
        check({name, "_done_count"}, n_done, (kill == 0) ? 32'd1 : 32'd0);
        check({name, "_done_cycle"}, done_cyc, (kill == 0) ? LAT : 32'd0);
        check({name, "_result"}, result, exp);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3"};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min_min"};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max_max"};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "mulhsu_m1_2"};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2"};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2"};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       "divu_100_7"};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        "remu_100_7"};
        vecs[8]  = '{3'b101, 32'h00000055, 32'd0,        32'hFFFFFFFF, "divu_by_zero"};
        vecs[9]  = '{3'b110, 32'h00001234, 32'd0,        32'h00001234, "rem_by_zero"};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_overflow"};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        "rem_overflow"};
        vecs[12] = '{3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, "div_neg_by_zero"};
        vecs[13] = '{3'b001, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF, "mulh_m1_3"};
        vecs[14] = '{3'b000, 32'h12345678, 32'h10,       32'h23456780, "mul_shift"};
        vecs[15] = '{3'b111, 32'hFFFFFFF9, 32'd2,        32'd1,        "remu_big_2"};

        rst   = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 0, 0);
        end

        // Starts in cycles 5, 33 and the DONE cycle are ignored; the next op starts in cycle 35.
        run_op("mul_ignored_starts", 3'b000, 32'd3, 32'd5, 32'd15, 1'b1, 0, 0);

        // Flush in cycle 10: no done, result keeps the previous 15.
        run_op("divu_flushed", 3'b101, 32'd100, 32'd7, 32'd15, 1'b0, 10, 0);

        start = 1'b1;
        flush = 1'b1;
        op    = 3'b000;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        check("flush_start_idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_start_idle_after", {30'd0, busy, done}, 32'd0);
        check("flush_start_idle_result", result, 32'd15);

        run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, 0, 0);

        // Reset in cycle 20 of a DIV clears everything, then a fresh DIVU must still work.
        run_op("div_reset", 3'b100, 32'd100, 32'd7, 32'd0, 1'b0, 0, 20);
        run_op("divu_after_reset", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
